// File: rtl/mcp4922_spi_monitor.sv
// Passive MCP4922 SPI bus monitor: decodes 16-bit frames per chip, mirrors DAC input/output registers, flags protocol errors.
// Optional config-bit check enabled by defining SPI_MON_CFG_CHECK_EN (adds err_cfg output).
module mcp4922_spi_monitor #(
  parameter int          NUM_CHIPS    = 12,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [2:0]  EXPECTED_CFG = 3'b011
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      spi_sck,
  input  logic                      spi_sdi,
  input  logic [NUM_CHIPS-1:0]      dac_cs,
  input  logic                      dac_ldac,
  output logic [24*NUM_CHIPS-1:0]   input_regs,
  output logic [24*NUM_CHIPS-1:0]   latched_regs,
  output logic [2*NUM_CHIPS-1:0]    shdn_mask,
  output logic                      frame_valid,
  output logic [4:0]                frame_chan,
  output logic [15:0]               frame_word,
  output logic                      ldac_pulse,
  output logic                      err_pulse,
  output logic [1:0]                err_code,
  output logic [15:0]               frame_count,
`ifdef SPI_MON_CFG_CHECK_EN
  output logic [7:0]                err_count,
  output logic                      err_cfg
`else
  output logic [7:0]                err_count
`endif
);

  localparam int NCH    = 2 * NUM_CHIPS;
  localparam int CIW    = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;
  localparam int PW     = NUM_CHIPS + 3;
  localparam int P_LDAC = NUM_CHIPS;
  localparam int P_SDI  = NUM_CHIPS + 1;
  localparam int P_SCK  = NUM_CHIPS + 2;
  // Reset the input pipeline to bus-idle levels so release of reset creates no spurious edges.
  localparam logic [PW-1:0] PINS_IDLE = {3'b001, {NUM_CHIPS{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  // ---------------- synchronizer and edge detector ----------------
  logic [PW-1:0]                   pins;
  logic [SYNC_STAGES-1:0][PW-1:0]  sync_q, sync_d;
  logic [PW-1:0]                   pin_s;
  logic [PW-1:0]                   lvl_q, lvl_d;
  logic                            sck_rise_q, sck_rise_d;
  logic                            ldac_fall_q, ldac_fall_d;
  logic [NUM_CHIPS-1:0]            cs_rise_q, cs_rise_d;
  logic [NUM_CHIPS-1:0]            cs_fall_q, cs_fall_d;

  assign pins  = {spi_sck, spi_sdi, dac_ldac, dac_cs};
  assign pin_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], pins};
    lvl_d       = pin_s;
    sck_rise_d  = pin_s[P_SCK] & ~lvl_q[P_SCK];
    ldac_fall_d = ~pin_s[P_LDAC] & lvl_q[P_LDAC];
    cs_rise_d   = pin_s[NUM_CHIPS-1:0] & ~lvl_q[NUM_CHIPS-1:0];
    cs_fall_d   = ~pin_s[NUM_CHIPS-1:0] & lvl_q[NUM_CHIPS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= {SYNC_STAGES{PINS_IDLE}};
      lvl_q       <= PINS_IDLE;
      sck_rise_q  <= 1'b0;
      ldac_fall_q <= 1'b0;
      cs_rise_q   <= '0;
      cs_fall_q   <= '0;
    end else begin
      sync_q      <= sync_d;
      lvl_q       <= lvl_d;
      sck_rise_q  <= sck_rise_d;
      ldac_fall_q <= ldac_fall_d;
      cs_rise_q   <= cs_rise_d;
      cs_fall_q   <= cs_fall_d;
    end
  end

  // lvl_q is the synchronized level aligned with the registered edge events.
  logic [NUM_CHIPS-1:0] cs_lvl;
  logic                 sdi_lvl;
  logic                 ldac_lvl;
  assign cs_lvl   = lvl_q[NUM_CHIPS-1:0];
  assign sdi_lvl  = lvl_q[P_SDI];
  assign ldac_lvl = lvl_q[P_LDAC];

  // ---------------- state and datapath registers ----------------
  state_t               state_q, state_d;
  logic [CIW-1:0]       chip_q, chip_d;
  logic [15:0]          shift_q, shift_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [24*NUM_CHIPS-1:0] in_q, in_d;
  logic [24*NUM_CHIPS-1:0] lat_q, lat_d;
  logic [NCH-1:0]       shdn_q, shdn_d;
  logic                 frame_valid_q, frame_valid_d;
  logic [4:0]           frame_chan_q, frame_chan_d;
  logic [15:0]          frame_word_q, frame_word_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic                 ldac_pulse_q, ldac_pulse_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [7:0]           err_count_q, err_count_d;
`ifdef SPI_MON_CFG_CHECK_EN
  logic                 err_cfg_q, err_cfg_d;
`endif

  // ---------------- chip-select decode ----------------
  logic                 any_low;
  logic                 multi_low;
  logic [CIW-1:0]       low_idx;
  logic [NUM_CHIPS-1:0] act_mask;
  logic                 other_fall;
  logic                 other_low;
  logic                 act_rise;

  always_comb begin
    any_low   = 1'b0;
    multi_low = 1'b0;
    low_idx   = '0;
    for (int i = NUM_CHIPS - 1; i >= 0; i--) begin
      if (!cs_lvl[i]) begin
        multi_low = multi_low | any_low;
        any_low   = 1'b1;
        low_idx   = CIW'(i);
      end
    end
    act_mask   = {{(NUM_CHIPS-1){1'b0}}, 1'b1} << chip_q;
    other_fall = |(cs_fall_q & ~act_mask);
    other_low  = |(~cs_lvl & ~act_mask);
    act_rise   = |(cs_rise_q & act_mask);
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (|cs_fall_q) state_d = multi_low ? S_WAIT : S_SHIFT;
      end
      S_SHIFT: begin
        if (other_fall || (act_rise && other_low)) state_d = S_WAIT;
        else if (act_rise)                         state_d = S_COMMIT;
      end
      S_COMMIT: state_d = S_IDLE;
      S_WAIT: begin
        if (&cs_lvl) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs and datapath ----------------
  logic              accept;
  logic              err_set;
  logic [1:0]        new_code;
  logic [CIW:0]      chan;
  logic              cnt_err;

  assign chan = {chip_q, shift_q[15]};

  always_comb begin
    chip_d        = chip_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    in_d          = in_q;
    lat_d         = lat_q;
    shdn_d        = shdn_q;
    frame_valid_d = 1'b0;
    frame_chan_d  = frame_chan_q;
    frame_word_d  = frame_word_q;
    frame_count_d = frame_count_q;
    ldac_pulse_d  = 1'b0;
    err_pulse_d   = 1'b0;
    err_code_d    = err_code_q;
    err_count_d   = err_count_q;
    accept        = 1'b0;
    err_set       = 1'b0;
    new_code      = 2'd0;
    cnt_err       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|cs_fall_q) begin
          if (multi_low) begin
            err_set  = 1'b1;
            new_code = 2'd2;
          end else begin
            chip_d    = low_idx;
            shift_d   = '0;
            bit_cnt_d = '0;
          end
        end
      end
      S_SHIFT: begin
        if (sck_rise_q) begin
          shift_d = {shift_q[14:0], sdi_lvl};
          if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
        end
        if (other_fall || (act_rise && other_low)) begin
          err_set  = 1'b1;
          new_code = 2'd3;
        end
      end
      S_COMMIT: begin
        if (bit_cnt_q == 5'd16) begin
          accept = 1'b1;
        end else begin
          err_set  = 1'b1;
          new_code = 2'd1;
        end
      end
      default: ;
    endcase

    if (accept) begin
      in_d[12*int'(chan) +: 12] = shift_q[11:0];
      shdn_d[chan]              = ~shift_q[12];
      // LDAC held low makes the output register transparent.
      if (!ldac_lvl) lat_d[12*int'(chan) +: 12] = shift_q[11:0];
      frame_valid_d = 1'b1;
      frame_chan_d  = 5'(chan);
      frame_word_d  = shift_q;
      frame_count_d = frame_count_q + 16'd1;
    end

    // Copy from in_d so a same-cycle commit is included in the latch.
    if (ldac_fall_q) begin
      lat_d        = in_d;
      ldac_pulse_d = 1'b1;
    end

    if (err_set) begin
      err_pulse_d = 1'b1;
      err_code_d  = new_code;
    end
    cnt_err = err_set;

`ifdef SPI_MON_CFG_CHECK_EN
    err_cfg_d = accept && (shift_q[14:12] != EXPECTED_CFG);
    cnt_err   = err_set | err_cfg_d;
`endif

    if (cnt_err && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chip_q        <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      in_q          <= '0;
      lat_q         <= '0;
      shdn_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_chan_q  <= '0;
      frame_word_q  <= '0;
      frame_count_q <= '0;
      ldac_pulse_q  <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_code_q    <= '0;
      err_count_q   <= '0;
`ifdef SPI_MON_CFG_CHECK_EN
      err_cfg_q     <= 1'b0;
`endif
    end else begin
      chip_q        <= chip_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      in_q          <= in_d;
      lat_q         <= lat_d;
      shdn_q        <= shdn_d;
      frame_valid_q <= frame_valid_d;
      frame_chan_q  <= frame_chan_d;
      frame_word_q  <= frame_word_d;
      frame_count_q <= frame_count_d;
      ldac_pulse_q  <= ldac_pulse_d;
      err_pulse_q   <= err_pulse_d;
      err_code_q    <= err_code_d;
      err_count_q   <= err_count_d;
`ifdef SPI_MON_CFG_CHECK_EN
      err_cfg_q     <= err_cfg_d;
`endif
    end
  end

  assign input_regs   = in_q;
  assign latched_regs = lat_q;
  assign shdn_mask    = shdn_q;
  assign frame_valid  = frame_valid_q;
  assign frame_chan   = frame_chan_q;
  assign frame_word   = frame_word_q;
  assign ldac_pulse   = ldac_pulse_q;
  assign err_pulse    = err_pulse_q;
  assign err_code     = err_code_q;
  assign frame_count  = frame_count_q;
  assign err_count    = err_count_q;
`ifdef SPI_MON_CFG_CHECK_EN
  assign err_cfg      = err_cfg_q;
`endif

endmodule
